// File: rtl/serial_wide_adder_pkg.sv
// Shared types and constants for the byte-serial wide adder.
package serial_wide_adder_pkg;

  // Width of one processed slice of the operands.
  localparam int unsigned ByteW = 8;

  // Transaction phases: wait for operands, add one byte per cycle, hold result.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

endpackage

// File: rtl/serial_wide_adder_if.sv
// Operand/result handshake bundle for the byte-serial wide adder.
interface serial_wide_adder_if
  import serial_wide_adder_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [ByteW*NBYTES-1:0] din_a;
  logic [ByteW*NBYTES-1:0] din_b;
  logic                    cin;
  logic                    out_valid;
  logic                    out_ready;
  logic [ByteW*NBYTES-1:0] sum;
  logic                    cout;

  // Producer/consumer side (testbench or upstream logic).
  modport master (
    output in_valid, din_a, din_b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  // Adder side.
  modport slave (
    input  in_valid, din_a, din_b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/serial_wide_adder_byte_adder_slice.sv
// Combinational one-byte full adder: s = a + b + ci, co = carry out.
module byte_adder_slice
  import serial_wide_adder_pkg::*;
(
  input  logic [ByteW-1:0] a,
  input  logic [ByteW-1:0] b,
  input  logic             ci,
  output logic [ByteW-1:0] s,
  output logic             co
);

  logic [ByteW:0] full;

  // Widen by one bit so the carry falls out of the top of the add.
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{ByteW{1'b0}}, ci};
    s    = full[ByteW-1:0];
    co   = full[ByteW];
  end

endmodule

// File: rtl/serial_wide_adder.sv
// Byte-serial wide adder: one shared 8-bit adder walks the operands LSB first,
// producing A+B+cin and the final carry NBYTES cycles after acceptance.
module serial_wide_adder
  import serial_wide_adder_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input logic                clk,
  input logic                rst_n,
  serial_wide_adder_if.slave bus
);

  localparam int unsigned W    = ByteW * NBYTES;
  localparam int unsigned CntW = $clog2(NBYTES);
  localparam logic [CntW-1:0] LastCnt = CntW'(NBYTES - 1);

  state_t            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      sum_q;
  logic              cout_q;

  logic [ByteW-1:0]  a_byte;
  logic [ByteW-1:0]  b_byte;
  logic [ByteW-1:0]  s_byte;
  logic              co_byte;

  // Select the byte pair addressed by the counter.
  always_comb begin
    a_byte = a_q[cnt_q*ByteW +: ByteW];
    b_byte = b_q[cnt_q*ByteW +: ByteW];
  end

  byte_adder_slice u_slice (
    .a  (a_byte),
    .b  (b_byte),
    .ci (carry_q),
    .s  (s_byte),
    .co (co_byte)
  );

  // Transaction FSM plus operand, carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.din_a;
            b_q     <= bus.din_b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[cnt_q*ByteW +: ByteW] <= s_byte;
          carry_q                     <= co_byte;
          cnt_q                       <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            cout_q  <= co_byte;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake flags depend on the state register only.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_wide_adder.sv
// Self-checking bench for serial_wide_adder: directed corner vectors, hold,
// mid-transaction reset and a streaming run against an arithmetic model.
module tb_serial_wide_adder;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  serial_wide_adder_if #(.NBYTES(NB)) bus ();

  serial_wide_adder #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (W+1)-bit addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Present one transaction, check latency and result, then release it.
  task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
    logic [W:0] exp;
    int lat;
    exp = ref_add(a, b, c);
    bus.din_a    = a;
    bus.din_b    = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    lat = 0;
    while (!bus.in_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Scramble the inputs: the captured copy must be what gets added.
    bus.din_a = $urandom;
    bus.din_b = $urandom;
    bus.cin   = 1'($urandom);
    check_eq({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (lat < 20) begin
      lat++;
      if (bus.out_valid) break;
      @(posedge clk); #1;
    end
    // lat counts the sample at which out_valid was seen, one per edge after accept.
    check_eq({tag, "_lat"}, 64'(lat), 64'(NB + 1));
    check_eq({tag, "_sum"}, 64'(bus.sum), 64'(exp[W-1:0]));
    check_eq({tag, "_cout"}, 64'(bus.cout), 64'(exp[W]));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_idle"}, 64'({bus.in_ready, bus.out_valid}), 64'b10);
  endtask

  logic [W:0]     q_exp[$];
  logic [W:0]     exp_v;
  logic [W-1:0]   ra;
  logic [W-1:0]   rb;
  logic           rc;
  logic           acc;
  logic           dlv;
  logic           reroll;
  logic           saw_valid;
  int             last_dlv;
  int             n_dlv;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.din_a     = '0;
    bus.din_b     = '0;
    bus.cin       = 1'b0;
    #1;
    check_eq("rst_state", 64'({bus.in_ready, bus.out_valid, bus.cout}), 64'b100);
    check_eq("rst_sum", 64'(bus.sum), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner vectors.
    run_txn("carry_chain", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    run_txn("mixed", 32'h1234_5678, 32'h1111_1111, 1'b1);
    run_txn("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_txn("rand", $urandom, $urandom, 1'($urandom));
    end

    // Result must hold in the done state while the consumer stalls.
    exp_v = ref_add(32'hDEAD_BEEF, 32'h3000_0001, 1'b0);
    bus.din_a = 32'hDEAD_BEEF;
    bus.din_b = 32'h3000_0001;
    bus.cin   = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (NB) @(posedge clk);
    #1;
    check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
    bus.din_a = '0;
    bus.din_b = '0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("hold_sum", 64'(bus.sum), 64'(exp_v[W-1:0]));
      check_eq("hold_flags", 64'({bus.cout, bus.in_ready, bus.out_valid}),
               64'({exp_v[W], 2'b01}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq("hold_release", 64'({bus.in_ready, bus.out_valid}), 64'b10);

    // Reset during RUN abandons the transaction.
    bus.din_a = 32'hCAFE_0000;
    bus.din_b = 32'h0000_F00D;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_flags", 64'({bus.in_ready, bus.out_valid, bus.cout}), 64'b100);
    check_eq("mid_rst_sum", 64'(bus.sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check_eq("post_rst_no_valid", 64'(saw_valid), 64'd0);
    run_txn("post_rst", 32'h8000_0000, 32'h8000_0000, 1'b1);

    // Streaming: both handshakes tied high, one result every NB+2 cycles.
    ra = $urandom;
    rb = $urandom;
    rc = 1'($urandom);
    bus.din_a = ra;
    bus.din_b = rb;
    bus.cin   = rc;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    last_dlv = -1;
    n_dlv    = 0;
    for (int i = 0; i < 70; i++) begin
      acc = bus.in_ready;
      dlv = bus.out_valid;
      if (dlv) begin
        if (q_exp.size() == 0) begin
          check_eq("stream_spurious", 64'd1, 64'd0);
        end else begin
          exp_v = q_exp.pop_front();
          check_eq("stream_sum", 64'(bus.sum), 64'(exp_v[W-1:0]));
          check_eq("stream_cout", 64'(bus.cout), 64'(exp_v[W]));
        end
        if (last_dlv >= 0) check_eq("stream_period", 64'(i - last_dlv), 64'(NB + 2));
        last_dlv = i;
        n_dlv++;
      end
      reroll = 1'b0;
      if (acc) begin
        q_exp.push_back(ref_add(ra, rb, rc));
        reroll = 1'b1;
      end
      @(posedge clk); #1;
      if (reroll) begin
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom);
        bus.din_a = ra;
        bus.din_b = rb;
        bus.cin   = rc;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("stream_count", 64'(n_dlv >= 10), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_wide_adder.md
SERIAL_WIDE_ADDER -- requirements
Module: serial_wide_adder

Interface
REQ-001 Parameter NBYTES, default 4: operand width in bytes; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands and carry-in presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 din_a  input  8*NBYTES  operand A, unsigned.
REQ-007 din_b  input  8*NBYTES  operand B, unsigned.
REQ-008 cin  input  1  carry-in to byte 0.
REQ-009 out_valid  output  1  sum and cout valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 sum  output  8*NBYTES  registered result, A+B+cin modulo 2^(8*NBYTES).
REQ-012 cout  output  1  registered carry out of the top byte.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; outputs decoded from registered state only.
REQ-014 IDLE: in_ready=1; in_valid=1 at an edge captures din_a, din_b, cin into internal registers, clears byte counter, goes to RUN.
REQ-015 RUN: each cycle adds byte[cnt] of A and B plus carry register through one 8-bit adder, writes result to sum byte cnt, loads carry register with the adder carry, increments cnt.
REQ-016 RUN exits to DONE on the edge processing byte NBYTES-1; cout loaded with that byte's carry on the same edge.
REQ-017 Latency: out_valid SHALL rise exactly NBYTES cycles after the accepting edge.
REQ-018 DONE: out_valid=1; sum and cout held stable until out_ready=1 at an edge, then IDLE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid there is ignored and captured operands stay unchanged.
REQ-020 No acceptance in DONE: minimum transaction period NBYTES+2 cycles.
REQ-021 Input changes after acceptance SHALL NOT affect the result.
REQ-022 sum bytes not yet written in RUN keep their previous values; only out_valid=1 qualifies sum.
REQ-023 out_ready outside DONE is ignored.

Reset
REQ-024 rst_n=0 forces state IDLE, cnt=0, carry register=0, sum=0, cout=0, out_valid=0, in_ready=1 immediately, regardless of edge.
REQ-025 Reset asserted during RUN or DONE SHALL abandon the transaction; no out_valid pulse after release.
REQ-026 First acceptance possible on the first rising edge with rst_n=1.

Structure
REQ-027 Shared package SHALL hold the state typedef (IDLE/RUN/DONE) and the byte-width constant 8.
REQ-028 Counter width SHALL be clog2(NBYTES), computed locally.
REQ-029 One sub-module, byte_adder_slice: combinational 8-bit a+b+ci -> 8-bit s, co; instantiated once and time-shared.

Verification
REQ-030 A=0x00000001, B=0xFFFFFFFF, cin=0 -> sum=0x00000000, cout=1, out_valid 4 cycles after accept (carry through all bytes).
REQ-031 A=0x12345678, B=0x11111111, cin=1 -> sum=0x2345678A, cout=0.
REQ-032 A=0xFFFFFFFF, B=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1.
REQ-033 out_ready=0 for 5 cycles in DONE, new in_valid with A=B=0 -> sum/cout held, in_ready=0, new operands ignored; out_ready=1 -> IDLE next edge.
REQ-034 rst_n pulsed low after 2 RUN cycles -> all outputs at reset values at once; after release no out_valid; next transaction correct.
REQ-035 in_valid and out_ready tied 1, random operands -> one result per 6 cycles, each matching reference model A+B+cin.
